spi_slave_if: RTL and testbench



---
 rtl/spi_slave_if.sv | 98 +++++++++
 tb/tb_spi_slave_if.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 slave front end with synchronised pins, byte deserialiser and MISO serialiser.
// Optional SPI_ABORT_FLAG_EN adds a sticky abort_err flag for frames that end mid-byte.
module spi_slave_if #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   output logic       byte_sync,
   output logic [7:0] data_in,
   input  logic [7:0] data_out
`ifdef SPI_ABORT_FLAG_EN
   ,
   output logic       abort_err
`endif
);
   logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q, vld_q;
   logic                   sclk_d, cs_d, armed;
   logic [2:0]             bit_cnt;
   logic [6:0]             rx_shift, tx_shift;
   logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_start, cs_end;

   assign sclk_s    = sclk_q[SYNC_STAGES-1];
   assign cs_s      = cs_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   // armed blocks the reset value of the cs_n chain from faking a falling edge
   assign cs_start  = armed & cs_d & ~cs_s & ~miso_oe;
   assign cs_end    = miso_oe & cs_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q <= '0;
         cs_q   <= '1;
         mosi_q <= '0;
         vld_q  <= '0;
         sclk_d <= 1'b0;
         cs_d   <= 1'b1;
         armed  <= 1'b0;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
         cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
         vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         sclk_d <= sclk_s;
         cs_d   <= cs_s;
         armed  <= armed | (vld_q[SYNC_STAGES-1] & cs_s);
      end
   end

   // miso_oe doubles as the frame-active flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         byte_sync <= 1'b0;
         data_in   <= 8'h00;
         bit_cnt   <= 3'd0;
         rx_shift  <= 7'd0;
         tx_shift  <= 7'd0;
      end else begin
         byte_sync <= 1'b0;
         if (cs_start) begin
            bit_cnt  <= 3'd0;
            tx_shift <= data_out[6:0];
            miso     <= data_out[7];
            miso_oe  <= 1'b1;
         end else if (cs_end) begin
            bit_cnt <= 3'd0;
            miso_oe <= 1'b0;
         end else if (miso_oe && sclk_rise) begin
            rx_shift <= {rx_shift[5:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               data_in   <= {rx_shift, mosi_s};
               byte_sync <= 1'b1;
            end
         end else if (miso_oe && sclk_fall) begin
            tx_shift <= (bit_cnt == 3'd0) ? data_out[6:0] : {tx_shift[5:0], 1'b0};
            miso     <= (bit_cnt == 3'd0) ? data_out[7] : tx_shift[6];
         end
      end
   end

`ifdef SPI_ABORT_FLAG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         abort_err <= 1'b0;
      else
         abort_err <= (cs_end && bit_cnt != 3'd0) ? 1'b1 : cs_start ? 1'b0 : abort_err;
   end
`endif
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed bench for spi_slave_if with a tiny write/read decoder model.
module tb_spi_slave_if;
   logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic       miso, miso_oe, byte_sync;
   logic [7:0] data_in, data_out, drv = 8'h00, dec_out = 8'h00, mem = 8'h00, cmd = 8'h00;
   logic       dec_en = 1'b0, rd_pend = 1'b0, bs_d = 1'b0;
   int         idx = 0, n_sync = 0, n_wide = 0, n_cmp = 0, n_err = 0, base = 0;
   logic [7:0] rx0, rx1, rx2;
`ifdef SPI_ABORT_FLAG_EN
   logic       abort_err;
`endif

   spi_slave_if dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .byte_sync(byte_sync),
      .data_in(data_in), .data_out(data_out)
`ifdef SPI_ABORT_FLAG_EN
      , .abort_err(abort_err)
`endif
   );

   always #5 clk = ~clk;
   assign data_out = dec_en ? dec_out : drv;

   always @(posedge clk) begin
      if (byte_sync) n_sync <= n_sync + 1;
      if (byte_sync && bs_d) n_wide <= n_wide + 1;
      bs_d <= byte_sync;
   end

   // decoder: cmd 8'h85 writes the next byte, cmd 8'h05 returns it one clk after the second byte
   always @(posedge clk) begin
      rd_pend <= byte_sync && idx == 1 && cmd == 8'h05;
      if (rd_pend) dec_out <= mem;
      if (byte_sync && idx == 0) cmd <= data_in;
      if (byte_sync && idx == 1 && cmd == 8'h85) mem <= data_in;
      if (cs_n) idx <= 0;
      else if (byte_sync) idx <= idx + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, input logic [7:0] nxt, input int nb, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
         mosi = tx[i];
         if (i == 3) drv = nxt;
         tick(5);
         sclk = 1'b1;
         rx[i] = miso;
         tick(5);
         sclk = 1'b0;
      end
   endtask

   initial begin
      tick(3);
      rst = 1'b0;
      tick(20);
      chk("idle_miso", miso, 0);
      chk("idle_oe", miso_oe, 0);
      chk("idle_sync", n_sync, 0);
      chk("idle_data", data_in, 8'h00);

      drv = 8'hA5;
      tick(2);
      cs_n = 1'b0;
      tick(6);
      chk("oe_active", miso_oe, 1);
      xfer(8'h85, 8'h5A, 8, rx0);
      chk("miso_b0", rx0, 8'hA5);
      chk("sync_b0", n_sync, 1);
      chk("data_b0", data_in, 8'h85);
      xfer(8'h3C, 8'h5A, 8, rx1);
      chk("miso_b1", rx1, 8'h5A);
      chk("sync_b1", n_sync, 2);
      chk("data_b1", data_in, 8'h3C);
      tick(5);
      cs_n = 1'b1;
      tick(1);
      chk("oe_hold", miso_oe, 1);
      tick(3);
      chk("oe_drop", miso_oe, 0);
      chk("sync_width", n_wide, 0);

      dec_en = 1'b1;
      tick(10);
      cs_n = 1'b0;
      tick(6);
      xfer(8'h85, 8'h00, 8, rx0);
      xfer(8'h3C, 8'h00, 8, rx0);
      tick(5);
      cs_n = 1'b1;
      tick(10);
      cs_n = 1'b0;
      tick(6);
      xfer(8'h05, 8'h00, 8, rx0);
      xfer(8'h00, 8'h00, 8, rx1);
      xfer(8'h00, 8'h00, 8, rx2);
      chk("read_back", rx2, 8'h3C);
      tick(5);
      cs_n = 1'b1;
      dec_en = 1'b0;
      tick(10);

      base = n_sync;
      cs_n = 1'b0;
      tick(6);
      xfer(8'hFF, 8'h00, 5, rx0);
      tick(3);
      cs_n = 1'b1;
      tick(10);
      chk("abort_sync", n_sync, base);
      chk("abort_data", data_in, 8'h00);
`ifdef SPI_ABORT_FLAG_EN
      chk("abort_set", abort_err, 1);
`endif
      cs_n = 1'b0;
      tick(6);
`ifdef SPI_ABORT_FLAG_EN
      chk("abort_clr", abort_err, 0);
`endif
      xfer(8'h12, 8'h00, 8, rx0);
      chk("post_abort_data", data_in, 8'h12);
      chk("post_abort_sync", n_sync, base + 1);
      tick(5);
      cs_n = 1'b1;
      tick(10);

      drv = 8'hFF;
      cs_n = 1'b0;
      tick(6);
      xfer(8'hAB, 8'hFF, 4, rx0);
      rst = 1'b1;
      tick(1);
      chk("rst_oe", miso_oe, 0);
      chk("rst_miso", miso, 0);
      chk("rst_data", data_in, 8'h00);
      rst = 1'b0;
      base = n_sync;
      xfer(8'hC3, 8'hFF, 8, rx0);
      tick(10);
      chk("rst_nosync", n_sync, base);
      chk("rst_data_hold", data_in, 8'h00);
      chk("rst_oe_off", miso_oe, 0);
      chk("rst_miso_off", miso, 0);
      cs_n = 1'b1;
      tick(6);
      cs_n = 1'b0;
      tick(6);
      chk("refrm_oe", miso_oe, 1);
      xfer(8'h96, 8'hFF, 8, rx0);
      chk("refrm_data", data_in, 8'h96);
      chk("refrm_sync", n_sync, base + 1);
      chk("final_width", n_wide, 0);
      tick(5);
      cs_n = 1'b1;
      tick(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
